kl_wmask_splitter: RTL and testbench

- Sits on KLink directly upstream of kl2ml_bridge.
- kl2ml_bridge handles only maskless accesses: full 0xFF, or naturally aligned byte, half or word masks.
- This block takes KLink requests with arbitrary write masks. It splits each write into a sequence of naturally aligned byte, half and word writes, absorbs the intermediate write acks, and returns exactly one response upstream per accepted request.
- Reads and already-legal masks pass through as a single piece.

---
 rtl/kl_wmask_splitter_pkg.sv | 75 +++++++
 rtl/kl_mask_chunker.sv | 20 ++
 rtl/kl_wmask_splitter.sv | 180 ++++++++++++++++++
 tb/tb_kl_wmask_splitter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kl_wmask_splitter_pkg.sv
// Shared KLink encodings and the mask-splitting rule used by kl_wmask_splitter.
// chunk_of() picks the next naturally aligned piece out of a remaining byte mask.
package kl_wmask_splitter_pkg;

    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_HALF  = 3'd1,
        SZ_WORD  = 3'd2,
        SZ_DWORD = 3'd3
    } kl_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LOCAL = 2'd3
    } split_state_e;

    typedef struct packed {
        logic [7:0] mask;
        logic [2:0] off;
        kl_size_e   size;
    } chunk_t;

    function automatic chunk_t chunk_of(input logic [7:0] rem);
        chunk_t     c;
        logic [2:0] p;
        logic [7:0] m4;
        logic [7:0] m2;
        c.mask = 8'h00;
        c.off  = 3'd0;
        c.size = SZ_BYTE;
        p      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rem[i]) p = 3'(i);
        end
        m4 = 8'h0F << p;
        m2 = 8'h03 << p;
        if (rem == 8'hFF) begin
            c.mask = 8'hFF;
            c.size = SZ_DWORD;
        end else if (rem != 8'h00) begin
            c.off = p;
            if (p[1:0] == 2'b00 && (rem & m4) == m4) begin
                c.mask = m4;
                c.size = SZ_WORD;
            end else if (!p[0] && (rem & m2) == m2) begin
                c.mask = m2;
                c.size = SZ_HALF;
            end else begin
                c.mask = 8'h01 << p;
                c.size = SZ_BYTE;
            end
        end
        return c;
    endfunction

    // Number of pieces a write mask splits into (0 only for an empty mask).
    function automatic logic [3:0] count_pieces(input logic [7:0] mask);
        logic [7:0] r;
        logic [3:0] n;
        chunk_t     c;
        r = mask;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (r != 8'h00) begin
                c = chunk_of(r);
                r = r & ~c.mask;
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/kl_mask_chunker.sv
// Combinational chunk selector: next aligned byte/half/word/dword piece of a mask.
module kl_mask_chunker
    import kl_wmask_splitter_pkg::*;
(
    input  logic [7:0] rem,
    output logic [7:0] chunk_mask,
    output logic [2:0] chunk_off,
    output logic [2:0] chunk_size
);

    chunk_t c;

    always_comb begin
        c          = chunk_of(rem);
        chunk_mask = c.mask;
        chunk_off  = c.off;
        chunk_size = c.size;
    end

endmodule

// File: rtl/kl_wmask_splitter.sv
// KLink write-mask splitter: breaks arbitrary-mask writes into aligned pieces for
// kl2ml_bridge and returns exactly one upstream response per request.
//   state | meaning
//   IDLE  | ready for a new upstream request
//   ISSUE | presenting pieces downstream, counting early acks
//   WAIT  | all pieces issued, absorbing acks, forwarding the final one
//   LOCAL | block-generated write response (empty mask or unacked writes)
module kl_wmask_splitter
    import kl_wmask_splitter_pkg::*;
#(
    parameter int SRCID_W    = 5,
    parameter bit ACK_WRITES = 1'b1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        s_req_addr,
    input  logic               s_req_wen,
    input  logic [63:0]        s_req_wdata,
    input  logic [7:0]         s_req_wmask,
    input  logic [2:0]         s_req_size,
    input  logic [SRCID_W-1:0] s_req_srcid,
    input  logic               s_req_valid,
    output logic               s_req_ready,

    output logic [63:0]        s_resp_rdata,
    output logic               s_resp_ren,
    output logic [2:0]         s_resp_size,
    output logic [SRCID_W-1:0] s_resp_dstid,
    output logic               s_resp_valid,
    input  logic               s_resp_ready,

    output logic [31:0]        m_req_addr,
    output logic               m_req_wen,
    output logic [63:0]        m_req_wdata,
    output logic [7:0]         m_req_wmask,
    output logic [2:0]         m_req_size,
    output logic [SRCID_W-1:0] m_req_srcid,
    output logic               m_req_valid,
    input  logic               m_req_ready,

    input  logic [63:0]        m_resp_rdata,
    input  logic               m_resp_ren,
    input  logic [2:0]         m_resp_size,
    input  logic [SRCID_W-1:0] m_resp_dstid,
    input  logic               m_resp_valid,
    output logic               m_resp_ready
);

    split_state_e       state;
    logic [31:0]        addr_q;
    logic               wen_q;
    logic [63:0]        wdata_q;
    logic [7:0]         wmask_q;
    logic [2:0]         size_q;
    logic [SRCID_W-1:0] srcid_q;
    logic [7:0]         rem_q;
    logic [3:0]         npieces_q;
    logic [3:0]         issued_q;
    logic [3:0]         acks_q;

    logic [7:0]         ck_mask;
    logic [2:0]         ck_off;
    logic [2:0]         ck_size;

    logic               expect_resp;
    logic               absorbing;
    logic               last_ack;
    logic               last_piece;
    logic               req_hs;
    logic               fwd;
    logic               ack_drop;
    logic               final_hs;
    logic               local_resp;

    kl_mask_chunker u_chunker (
        .rem        (rem_q),
        .chunk_mask (ck_mask),
        .chunk_off  (ck_off),
        .chunk_size (ck_size)
    );

    // Reads go out exactly as captured; writes take the current chunk.
    always_comb begin
        m_req_addr  = wen_q ? {addr_q[31:3], ck_off} : addr_q;
        m_req_wen   = wen_q;
        m_req_wdata = wdata_q;
        m_req_wmask = wen_q ? ck_mask : wmask_q;
        m_req_size  = wen_q ? ck_size : size_q;
        m_req_srcid = srcid_q;
    end

    always_comb begin
        expect_resp = !wen_q || ACK_WRITES;
        absorbing   = !rst && (state == ST_ISSUE || state == ST_WAIT) && expect_resp;
        last_ack    = acks_q == (npieces_q - 4'd1);
        last_piece  = (issued_q + 4'd1) == npieces_q;
        req_hs      = m_req_valid && m_req_ready;
        // The last ack can only follow the last piece, so forwarding is tied to WAIT.
        fwd         = absorbing && last_ack && state == ST_WAIT;
        ack_drop    = absorbing && !last_ack && m_resp_valid;
        final_hs    = fwd && m_resp_valid && s_resp_ready;
        local_resp  = !rst && state == ST_LOCAL;

        m_resp_ready = fwd ? s_resp_ready : (absorbing && !last_ack);
        s_resp_valid = local_resp || (fwd && m_resp_valid);
        s_resp_rdata = (state == ST_LOCAL) ? 64'd0   : m_resp_rdata;
        s_resp_ren   = (state == ST_LOCAL) ? 1'b0    : m_resp_ren;
        s_resp_size  = (state == ST_LOCAL) ? size_q  : m_resp_size;
        s_resp_dstid = (state == ST_LOCAL) ? srcid_q : m_resp_dstid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            s_req_ready <= 1'b0;
            m_req_valid <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            size_q      <= '0;
            srcid_q     <= '0;
            rem_q       <= '0;
            npieces_q   <= '0;
            issued_q    <= '0;
            acks_q      <= '0;
        end else begin
            if (ack_drop) acks_q <= acks_q + 4'd1;
            case (state)
                ST_IDLE: begin
                    s_req_ready <= 1'b1;
                    if (s_req_valid && s_req_ready) begin
                        s_req_ready <= 1'b0;
                        addr_q      <= s_req_addr;
                        wen_q       <= s_req_wen;
                        wdata_q     <= s_req_wdata;
                        wmask_q     <= s_req_wmask;
                        size_q      <= s_req_size;
                        srcid_q     <= s_req_srcid;
                        rem_q       <= s_req_wmask;
                        npieces_q   <= s_req_wen ? count_pieces(s_req_wmask) : 4'd1;
                        issued_q    <= 4'd0;
                        acks_q      <= 4'd0;
                        if (s_req_wen && s_req_wmask == 8'h00) begin
                            state <= ST_LOCAL;
                        end else begin
                            state       <= ST_ISSUE;
                            m_req_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (req_hs) begin
                        issued_q <= issued_q + 4'd1;
                        rem_q    <= rem_q & ~ck_mask;
                        if (last_piece) begin
                            m_req_valid <= 1'b0;
                            state       <= expect_resp ? ST_WAIT : ST_LOCAL;
                        end
                    end
                end
                ST_WAIT: begin
                    if (final_hs) begin
                        state       <= ST_IDLE;
                        s_req_ready <= 1'b1;
                    end
                end
                ST_LOCAL: begin
                    if (s_resp_ready) begin
                        state       <= ST_IDLE;
                        s_req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kl_wmask_splitter.sv
// Directed bench for kl_wmask_splitter with a small downstream responder model.
`timescale 1ns/1ps
module tb_kl_wmask_splitter;

    typedef struct packed {
        logic [63:0] rdata;
        logic        ren;
        logic [2:0]  size;
        logic [4:0]  dstid;
    } resp_t;

    logic        clk;
    logic        rst;
    logic [31:0] s_req_addr;
    logic        s_req_wen;
    logic [63:0] s_req_wdata;
    logic [7:0]  s_req_wmask;
    logic [2:0]  s_req_size;
    logic [4:0]  s_req_srcid;
    logic        s_req_valid;
    logic        s_req_ready;
    logic [63:0] s_resp_rdata;
    logic        s_resp_ren;
    logic [2:0]  s_resp_size;
    logic [4:0]  s_resp_dstid;
    logic        s_resp_valid;
    logic        s_resp_ready;
    logic [31:0] m_req_addr;
    logic        m_req_wen;
    logic [63:0] m_req_wdata;
    logic [7:0]  m_req_wmask;
    logic [2:0]  m_req_size;
    logic [4:0]  m_req_srcid;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [63:0] m_resp_rdata;
    logic        m_resp_ren;
    logic [2:0]  m_resp_size;
    logic [4:0]  m_resp_dstid;
    logic        m_resp_valid;
    logic        m_resp_ready;

    int n_checks = 0;
    int n_errors = 0;

    // downstream model knobs and logs
    bit          stall_mode  = 0;
    bit          gap_mode    = 0;
    int          ready_limit = -1;
    bit          pop_pending = 0;
    resp_t       rq[$];
    resp_t       up_q[$];
    logic [31:0] log_addr[$];
    logic [7:0]  log_mask[$];
    logic [2:0]  log_size[$];
    logic [63:0] log_wdata[$];

    kl_wmask_splitter #(.SRCID_W(5), .ACK_WRITES(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req_addr   (s_req_addr),
        .s_req_wen    (s_req_wen),
        .s_req_wdata  (s_req_wdata),
        .s_req_wmask  (s_req_wmask),
        .s_req_size   (s_req_size),
        .s_req_srcid  (s_req_srcid),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_resp_rdata (s_resp_rdata),
        .s_resp_ren   (s_resp_ren),
        .s_resp_size  (s_resp_size),
        .s_resp_dstid (s_resp_dstid),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .m_req_addr   (m_req_addr),
        .m_req_wen    (m_req_wen),
        .m_req_wdata  (m_req_wdata),
        .m_req_wmask  (m_req_wmask),
        .m_req_size   (m_req_size),
        .m_req_srcid  (m_req_srcid),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_resp_rdata (m_resp_rdata),
        .m_resp_ren   (m_resp_ren),
        .m_resp_size  (m_resp_size),
        .m_resp_dstid (m_resp_dstid),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Downstream responder: inputs change at negedge, handshakes sampled 1ns later.
    initial begin
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
        m_resp_ren   = 1'b0;
        m_resp_size  = '0;
        m_resp_dstid = '0;
        forever begin
            @(negedge clk);
            if (pop_pending) begin
                void'(rq.pop_front());
                m_resp_valid = 1'b0;
                pop_pending  = 0;
            end
            if (rst) begin
                rq.delete();
                m_resp_valid = 1'b0;
                m_req_ready  = 1'b0;
            end else begin
                if (ready_limit >= 0 && log_mask.size() >= ready_limit)
                    m_req_ready = 1'b0;
                else if (stall_mode)
                    m_req_ready = 1'($urandom_range(0, 1));
                else
                    m_req_ready = 1'b1;
                if (!m_resp_valid && rq.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
                    m_resp_valid = 1'b1;
                    m_resp_rdata = rq[0].rdata;
                    m_resp_ren   = rq[0].ren;
                    m_resp_size  = rq[0].size;
                    m_resp_dstid = rq[0].dstid;
                end
            end
            #1;
            if (m_resp_valid && m_resp_ready) pop_pending = 1;
            if (m_req_valid && m_req_ready) begin
                log_addr.push_back(m_req_addr);
                log_mask.push_back(m_req_wmask);
                log_size.push_back(m_req_size);
                log_wdata.push_back(m_req_wdata);
                rq.push_back('{rdata: {m_req_addr, 24'h5A5A5A, m_req_wmask},
                               ren: !m_req_wen, size: m_req_size, dstid: m_req_srcid});
            end
        end
    end

    // Upstream response monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && s_resp_valid && s_resp_ready)
                up_q.push_back('{rdata: s_resp_rdata, ren: s_resp_ren,
                                 size: s_resp_size, dstid: s_resp_dstid});
        end
    end

    task automatic clear_logs();
        log_addr.delete();
        log_mask.delete();
        log_size.delete();
        log_wdata.delete();
        up_q.delete();
    endtask

    task automatic send_req(input logic [31:0] addr, input logic wen, input logic [63:0] wdata,
                            input logic [7:0] wmask, input logic [2:0] size, input logic [4:0] srcid);
        bit ok;
        ok = 0;
        @(negedge clk);
        s_req_addr  = addr;
        s_req_wen   = wen;
        s_req_wdata = wdata;
        s_req_wmask = wmask;
        s_req_size  = size;
        s_req_srcid = srcid;
        s_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (s_req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_up(input string tag, input int want);
        for (int i = 0; i < 300; i++) begin
            if (up_q.size() >= want) break;
            @(negedge clk);
        end
        check({tag, "_resp_cnt"}, up_q.size(), want);
    endtask

    task automatic check_piece(input string tag, input int i, input logic [31:0] addr,
                               input logic [7:0] mask, input logic [2:0] size);
        if (i < log_addr.size()) begin
            check({tag, "_addr"}, log_addr[i], addr);
            check({tag, "_mask"}, log_mask[i], mask);
            check({tag, "_size"}, log_size[i], size);
        end else begin
            check({tag, "_missing"}, log_addr.size(), i + 1);
        end
    endtask

    task automatic check_resp(input string tag, input logic [63:0] rdata, input logic ren,
                              input logic [2:0] size, input logic [4:0] dstid);
        resp_t r;
        if (up_q.size() > 0) begin
            r = up_q.pop_front();
            check({tag, "_rdata"}, r.rdata, rdata);
            check({tag, "_ren"},   r.ren,   ren);
            check({tag, "_size"},  r.size,  size);
            check({tag, "_dstid"}, r.dstid, dstid);
        end else begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        logic [63:0] held;
        rst          = 1'b1;
        s_req_valid  = 1'b0;
        s_req_addr   = '0;
        s_req_wen    = 1'b0;
        s_req_wdata  = '0;
        s_req_wmask  = '0;
        s_req_size   = '0;
        s_req_srcid  = '0;
        s_resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_s_req_ready",  s_req_ready,  0);
        check("rst_m_req_valid",  m_req_valid,  0);
        check("rst_s_resp_valid", s_resp_valid, 0);
        check("rst_m_resp_ready", m_resp_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rdy_after_rst", s_req_ready, 1);

        // 0x6D -> 0x01, 0x0C, 0x20, 0x40
        clear_logs();
        send_req(32'h1000_0008, 1'b1, 64'h1122_3344_5566_7788, 8'h6D, 3'd3, 5'd3);
        wait_up("A", 1);
        repeat (4) @(negedge clk);
        check("A_npieces", log_mask.size(), 4);
        check_piece("A_p0", 0, 32'h1000_0008, 8'h01, 3'd0);
        check_piece("A_p1", 1, 32'h1000_000A, 8'h0C, 3'd1);
        check_piece("A_p2", 2, 32'h1000_000D, 8'h20, 3'd0);
        check_piece("A_p3", 3, 32'h1000_000E, 8'h40, 3'd0);
        if (log_wdata.size() > 2) check("A_wdata", log_wdata[2], 64'h1122_3344_5566_7788);
        check("A_one_resp", up_q.size(), 1);
        check_resp("A_resp", {32'h1000_000E, 24'h5A5A5A, 8'h40}, 1'b0, 3'd0, 5'd3);

        // 0xFF then 0xF0: single pieces, ack forwarded unchanged
        clear_logs();
        send_req(32'h2000_0010, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 3'd3, 5'd1);
        wait_up("FF", 1);
        repeat (2) @(negedge clk);
        check("FF_npieces", log_mask.size(), 1);
        check_piece("FF_p0", 0, 32'h2000_0010, 8'hFF, 3'd3);
        check_resp("FF_resp", {32'h2000_0010, 24'h5A5A5A, 8'hFF}, 1'b0, 3'd3, 5'd1);
        clear_logs();
        send_req(32'h2000_0010, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 3'd3, 5'd1);
        wait_up("F0", 1);
        repeat (2) @(negedge clk);
        check("F0_npieces", log_mask.size(), 1);
        check_piece("F0_p0", 0, 32'h2000_0014, 8'hF0, 3'd2);
        check_resp("F0_resp", {32'h2000_0014, 24'h5A5A5A, 8'hF0}, 1'b0, 3'd2, 5'd1);

        // Read with gappy downstream response and upstream back-pressure
        clear_logs();
        gap_mode = 1;
        @(negedge clk);
        s_resp_ready = 1'b0;
        send_req(32'h3000_0020, 1'b0, 64'd0, 8'h3C, 3'd3, 5'd5);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (s_resp_valid) break;
        end
        check("RD_valid", s_resp_valid, 1);
        held = s_resp_rdata;
        repeat (3) begin
            @(negedge clk);
            #2;
            check("RD_hold_valid", s_resp_valid, 1);
            check("RD_hold_rdata", s_resp_rdata, held);
            check("RD_hold_dstid", s_resp_dstid, 5);
        end
        @(negedge clk);
        s_resp_ready = 1'b1;
        wait_up("RD", 1);
        gap_mode = 0;
        repeat (2) @(negedge clk);
        check("RD_npieces", log_mask.size(), 1);
        check_piece("RD_p0", 0, 32'h3000_0020, 8'h3C, 3'd3);
        check_resp("RD_resp", {32'h3000_0020, 24'h5A5A5A, 8'h3C}, 1'b1, 3'd3, 5'd5);

        // Empty write mask: local response the cycle after capture
        clear_logs();
        send_req(32'h4000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'd2, 5'd7);
        #2;
        check("Z_valid_next", s_resp_valid, 1);
        wait_up("Z", 1);
        repeat (3) @(negedge clk);
        check("Z_npieces", log_mask.size(), 0);
        check_resp("Z_resp", 64'd0, 1'b0, 3'd2, 5'd7);

        // 0xFE with random downstream stalls
        clear_logs();
        stall_mode = 1;
        send_req(32'h5000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFE, 3'd3, 5'd9);
        wait_up("FE", 1);
        stall_mode = 0;
        repeat (4) @(negedge clk);
        check("FE_npieces", log_mask.size(), 3);
        check_piece("FE_p0", 0, 32'h5000_0001, 8'h02, 3'd0);
        check_piece("FE_p1", 1, 32'h5000_0002, 8'h0C, 3'd1);
        check_piece("FE_p2", 2, 32'h5000_0004, 8'hF0, 3'd2);
        check("FE_one_resp", up_q.size(), 1);
        check_resp("FE_resp", {32'h5000_0004, 24'h5A5A5A, 8'hF0}, 1'b0, 3'd2, 5'd9);

        // Reset in ISSUE after 2 of 4 pieces
        clear_logs();
        ready_limit = 2;
        send_req(32'h6000_0000, 1'b1, 64'd0, 8'h6D, 3'd3, 5'd4);
        for (int i = 0; i < 100; i++) begin
            if (log_mask.size() >= 2) break;
            @(negedge clk);
        end
        check("R_two_pieces", log_mask.size(), 2);
        @(negedge clk);
        #1;
        check("R_stalled_valid", m_req_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("R_m_req_valid",  m_req_valid,  0);
        check("R_s_resp_valid", s_resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        ready_limit = -1;
        @(negedge clk);
        #1;
        check("R_rdy_after", s_req_ready, 1);
        send_req(32'h7000_0008, 1'b0, 64'd0, 8'h0F, 3'd2, 5'd2);
        wait_up("R2", 1);
        repeat (2) @(negedge clk);
        check("R2_npieces", log_mask.size(), 1);
        check_piece("R2_p0", 0, 32'h7000_0008, 8'h0F, 3'd2);
        check_resp("R2_resp", {32'h7000_0008, 24'h5A5A5A, 8'h0F}, 1'b1, 3'd2, 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
